// File: rtl/frame_sram_arbiter_if.sv
// Request/response bundle between the three frame-buffer requesters, the
// arbiter and the SRAM wrapper.
interface frame_sram_arbiter_if #(
   parameter int ADDR_BITS   = 30,
   parameter int ACCESS_BITS = 1536
);
   logic [2:0]             req;
   logic [2:0]             wen;
   logic [2:0]             lock;
   logic                   urgent;
   logic [ADDR_BITS-1:0]   addr0, addr1, addr2;
   logic [ACCESS_BITS-1:0] wdata0, wdata1, wdata2;
   logic [2:0]             gnt;
   logic [2:0]             ack;
   logic [ACCESS_BITS-1:0] rdata;
   logic [ADDR_BITS-1:0]   mem_addr;
   logic [ACCESS_BITS-1:0] mem_wdata;
   logic                   mem_r_en;
   logic                   mem_w_en;
   logic [ACCESS_BITS-1:0] mem_rdata;
   logic                   busy;

   modport slave (
      input  req, wen, lock, urgent, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
      output gnt, ack, rdata, mem_addr, mem_wdata, mem_r_en, mem_w_en, busy
   );

   modport master (
      output req, wen, lock, urgent, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
      input  gnt, ack, rdata, mem_addr, mem_wdata, mem_r_en, mem_w_en, busy
   );
endinterface

// File: rtl/frame_sram_arbiter.sv
// Three-way frame-buffer SRAM arbiter: urgent display override, bounded burst
// lock, then round-robin. One latched access at a time, acked with read data.
module frame_sram_arbiter #(
   parameter int ADDR_BITS   = 30,
   parameter int ACCESS_BITS = 1536,
   parameter int WAIT_CYCLES = 1,
   parameter int MAX_BURST   = 64
) (
   input  logic                 clk,
   input  logic                 n_rst,
   frame_sram_arbiter_if.slave  bus
);
   localparam int WCW = $clog2(WAIT_CYCLES) + 1;
   localparam int BCW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                 r_state, w_next;
   logic [1:0]             r_win, r_rr, w_win;
   logic [BCW-1:0]         r_burst;
   logic [WCW-1:0]         r_wait;
   logic                   r_wen, r_r_en, r_w_en;
   logic [ADDR_BITS-1:0]   r_addr, w_addr;
   logic [ACCESS_BITS-1:0] r_wdata, r_rdata, w_wdata;
   logic [2:0]             r_ack, w_gnt;
   logic                   w_accept, w_xfer, w_lock_ok, w_last;

   function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
      int s;
      s = int'(p) + k;
      return 2'(s % 3);
   endfunction

   always_comb begin
      w_accept  = (r_state != ACCESS);
      w_xfer    = w_accept && (|bus.req);
      w_lock_ok = (r_state == RESP) && bus.lock[r_win] && bus.req[r_win] &&
                  (r_burst < BCW'(MAX_BURST));
      // descending scan so the requester closest to rr_ptr wins
      w_win = r_rr;
      for (int k = 2; k >= 0; k--) begin
         if (bus.req[rr_idx(r_rr, k)]) w_win = rr_idx(r_rr, k);
      end
      if (w_lock_ok) w_win = r_win;
      if (bus.urgent && bus.req[2]) w_win = 2'd2;
      w_gnt = w_xfer ? (3'b001 << w_win) : 3'b000;
   end

   always_comb begin
      case (w_win)
         2'd1:    begin w_addr = bus.addr1; w_wdata = bus.wdata1; end
         2'd2:    begin w_addr = bus.addr2; w_wdata = bus.wdata2; end
         default: begin w_addr = bus.addr0; w_wdata = bus.wdata0; end
      endcase
   end

   always_comb begin
      w_next = r_state;
      w_last = (r_wait == WCW'(WAIT_CYCLES - 1));
      case (r_state)
         IDLE, RESP: w_next = (|bus.req) ? ACCESS : IDLE;
         ACCESS:     if (w_last) w_next = RESP;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
         r_win   <= 2'd0;
         r_rr    <= 2'd0;
         r_burst <= '0;
         r_wait  <= '0;
         r_wen   <= 1'b0;
         r_r_en  <= 1'b0;
         r_w_en  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ack   <= 3'b000;
      end else begin
         r_state <= w_next;
         r_ack   <= 3'b000;
         if (w_xfer) begin
            r_win   <= w_win;
            r_rr    <= rr_idx(w_win, 1);
            // only a lock-kept grant extends the burst; anything else starts a new one
            r_burst <= (w_lock_ok && (w_win == r_win)) ? r_burst + BCW'(1) : BCW'(1);
            r_wait  <= '0;
            r_wen   <= bus.wen[w_win];
            r_r_en  <= ~bus.wen[w_win];
            r_w_en  <= bus.wen[w_win];
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
         end else if (r_state == ACCESS) begin
            r_wait <= r_wait + WCW'(1);
            if (w_last) begin
               r_r_en <= 1'b0;
               r_w_en <= 1'b0;
               r_ack  <= 3'b001 << r_win;
               if (!r_wen) r_rdata <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.gnt       = w_gnt;
   assign bus.ack       = r_ack;
   assign bus.rdata     = r_rdata;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_r_en  = r_r_en;
   assign bus.mem_w_en  = r_w_en;
   assign bus.busy      = (r_state == ACCESS);
endmodule

// File: tb/tb_frame_sram_arbiter.sv
// Bench: transaction-level reference model for the arbiter (WAIT_CYCLES=1,
// MAX_BURST=4) plus directed latency/reset checks on a WAIT_CYCLES=3 instance.
module tb_frame_sram_arbiter;
   localparam int AB = 30;
   localparam int DB = 1536;
   localparam int W  = 1;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic n_rst3 = 1'b0;
   always #5 clk = ~clk;

   frame_sram_arbiter_if #(.ADDR_BITS(AB), .ACCESS_BITS(DB)) bus ();
   frame_sram_arbiter_if #(.ADDR_BITS(AB), .ACCESS_BITS(DB)) bus3 ();

   frame_sram_arbiter #(.ADDR_BITS(AB), .ACCESS_BITS(DB), .WAIT_CYCLES(W), .MAX_BURST(MB))
      dut (.clk(clk), .n_rst(n_rst), .bus(bus));
   frame_sram_arbiter #(.ADDR_BITS(AB), .ACCESS_BITS(DB), .WAIT_CYCLES(3), .MAX_BURST(64))
      dut3 (.clk(clk), .n_rst(n_rst3), .bus(bus3));

   // requester-side drive for the main instance
   logic [2:0]    t_req = '0, t_wen = '0, t_lock = '0;
   logic          t_urg = 1'b0;
   logic [AB-1:0] t_addr [3];
   logic [DB-1:0] t_wdata [3];
   assign bus.req = t_req;   assign bus.wen = t_wen;   assign bus.lock = t_lock;
   assign bus.urgent = t_urg;
   assign bus.addr0 = t_addr[0];   assign bus.addr1 = t_addr[1];   assign bus.addr2 = t_addr[2];
   assign bus.wdata0 = t_wdata[0]; assign bus.wdata1 = t_wdata[1]; assign bus.wdata2 = t_wdata[2];

   // SRAM model for the main instance, with a preload port
   logic [DB-1:0] sram [0:1023];
   logic          pre_en = 1'b0;
   logic [9:0]    pre_a = '0;
   logic [DB-1:0] pre_d = '0;
   assign bus.mem_rdata = sram[bus.mem_addr[9:0]];
   always @(posedge clk) begin
      if (pre_en) sram[pre_a] <= pre_d;
      else if (bus.mem_w_en) sram[bus.mem_addr[9:0]] <= bus.mem_wdata;
   end

   // second instance: simple drive, SRAM returns an address-derived pattern
   logic [2:0]    u_req = '0, u_wen = '0;
   logic [AB-1:0] u_addr0 = '0;
   assign bus3.req = u_req;  assign bus3.wen = u_wen;  assign bus3.lock = 3'b000;
   assign bus3.urgent = 1'b0;
   assign bus3.addr0 = u_addr0;  assign bus3.addr1 = '0;  assign bus3.addr2 = '0;
   assign bus3.wdata0 = {48{32'hA5A5_0001}};  assign bus3.wdata1 = '0;  assign bus3.wdata2 = '0;
   assign bus3.mem_rdata = {48{2'b00, bus3.mem_addr}};

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [DB-1:0] ref_mem [0:1023];
   int            m_left, m_owner, m_rr, m_burst;
   logic [2:0]    m_ack, pend, outst;
   logic          m_wen;
   logic [AB-1:0] m_addr;
   logic [DB-1:0] m_wdata, m_rdata;
   int            glog[$];
   int            alog[$];

   task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [DB-1:0] pre_val(input int a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
      return {48{h}};
   endfunction

   function automatic logic [DB-1:0] rand_data();
      logic [DB-1:0] d;
      d = '0;
      for (int k = 0; k < DB / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic model_reset();
      m_left = 0; m_owner = 0; m_rr = 0; m_burst = 0;
      m_ack = '0; pend = '0; outst = '0;
      m_wen = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
   endtask

   // winner by priority: urgent display, then kept lock (ack cycle only), then rotation
   function automatic int pick(input logic [2:0] rq, input logic [2:0] lk, input logic urg, input bit resp);
      if (urg && rq[2]) return 2;
      if (resp && lk[m_owner] && rq[m_owner] && m_burst < MB) return m_owner;
      for (int k = 0; k < 3; k++) if (rq[(m_rr + k) % 3]) return (m_rr + k) % 3;
      return -1;
   endfunction

   task automatic step();
      int win;
      bit acc, resp, kept;
      logic [2:0] eg;
      acc  = (m_left == 0);
      resp = (m_ack != 3'b000);
      win  = acc ? pick(t_req, t_lock, t_urg, resp) : -1;
      eg   = (win >= 0) ? 3'(1 << win) : 3'b000;
      @(negedge clk);
      chk("gnt", DB'(bus.gnt), DB'(eg));
      chk("ack", DB'(bus.ack), DB'(m_ack));
      chk("busy", DB'(bus.busy), DB'(!acc));
      chk("mem_r_en", DB'(bus.mem_r_en), DB'(!acc && !m_wen));
      chk("mem_w_en", DB'(bus.mem_w_en), DB'(!acc && m_wen));
      chk("mem_addr", DB'(bus.mem_addr), DB'(m_addr));
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("rdata", bus.rdata, m_rdata);
      for (int i = 0; i < 3; i++) begin
         if (bus.gnt[i]) glog.push_back(i);
         if (bus.ack[i]) alog.push_back(i);
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) if (m_ack[i]) outst[i] = 1'b0;
      m_ack = 3'b000;
      if (!acc) begin
         if (m_wen) ref_mem[m_addr[9:0]] = m_wdata;
         m_left--;
         if (m_left == 0) begin
            m_ack = 3'(1 << m_owner);
            if (!m_wen) m_rdata = ref_mem[m_addr[9:0]];
         end
      end
      if (win >= 0) begin
         kept    = resp && (win == m_owner) && t_lock[m_owner] && (m_burst < MB);
         m_burst = kept ? m_burst + 1 : 1;
         m_owner = win;
         m_rr    = (win + 1) % 3;
         m_left  = W;
         m_wen   = t_wen[win];
         m_addr  = t_addr[win];
         m_wdata = t_wdata[win];
         pend[win]  = 1'b0;
         outst[win] = 1'b1;
      end
      #1;
   endtask

   // a requester raises req only when idle or in its own ack cycle, then holds until granted
   task automatic drive(input logic [2:0] want, input logic [2:0] lk, input logic urg, input bit rnd);
      for (int i = 0; i < 3; i++) begin
         if (!pend[i] && want[i] && (!outst[i] || m_ack[i])) begin
            pend[i] = 1'b1;
            if (rnd) begin
               t_addr[i]  = AB'($urandom_range(0, 1023));
               t_wen[i]   = 1'($urandom_range(0, 1));
               t_wdata[i] = rand_data();
            end
         end
      end
      t_req = pend; t_lock = lk; t_urg = urg;
   endtask

   task automatic do_reset();
      t_req = '0; t_lock = '0; t_urg = 1'b0;
      n_rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
      n_rst = 1'b1;
   endtask

   task automatic drain();
      repeat (4) begin drive(3'b000, 3'b000, 1'b0, 1'b0); step(); end
   endtask

   initial begin
      logic [DB-1:0] pat;
      int exp_order [6];
      for (int i = 0; i < 3; i++) begin t_addr[i] = '0; t_wdata[i] = '0; end
      model_reset();
      for (int a = 0; a < 1024; a++) begin
         pre_en = 1'b1; pre_a = 10'(a); pre_d = pre_val(a); ref_mem[a] = pre_val(a);
         @(posedge clk); #1;
      end
      pre_en = 1'b0;

      // reset state, then single read of a preloaded word
      do_reset();
      step(); step();
      t_addr[0] = 30'h100; t_wen = 3'b000;
      drive(3'b001, 3'b000, 1'b0, 1'b0); step();
      drive(3'b000, 3'b000, 1'b0, 1'b0); step(); step();
      chk("single_read_data", bus.rdata, pre_val(30'h100));
      drain();

      // round-robin fairness with everyone requesting
      do_reset(); glog.delete(); alog.delete();
      t_addr[0] = 30'h11; t_addr[1] = 30'h22; t_addr[2] = 30'h33;
      repeat (13) begin drive(3'b111, 3'b000, 1'b0, 1'b0); step(); end
      exp_order = '{0, 1, 2, 0, 1, 2};
      chk("rr_ack_count", DB'(alog.size()), DB'(6));
      for (int k = 0; k < 6 && k < alog.size(); k++) chk("rr_ack_order", DB'(alog[k]), DB'(exp_order[k]));
      drain();

      // burst lock on requester 1 capped at MB grants
      do_reset(); glog.delete();
      drive(3'b010, 3'b010, 1'b0, 1'b0); step();
      repeat (13) begin drive(3'b011, 3'b010, 1'b0, 1'b0); step(); end
      exp_order = '{1, 1, 1, 1, 0, 1};
      for (int k = 0; k < 6 && k < glog.size(); k++) chk("burst_order", DB'(glog[k]), DB'(exp_order[k]));
      chk("burst_count", DB'(glog.size() >= 6), DB'(1));
      drain();

      // urgent display request arriving during a locked burst
      do_reset(); glog.delete();
      drive(3'b001, 3'b001, 1'b0, 1'b0); step();
      drive(3'b001, 3'b001, 1'b0, 1'b0); step();
      drive(3'b001, 3'b001, 1'b0, 1'b0); step();
      drive(3'b101, 3'b001, 1'b1, 1'b0); step();
      drive(3'b101, 3'b001, 1'b1, 1'b0); step();
      drive(3'b011, 3'b000, 1'b0, 1'b0); step();
      drive(3'b000, 3'b000, 1'b0, 1'b0); step();
      exp_order = '{0, 0, 2, 0, 0, 0};
      chk("urgent_count", DB'(glog.size()), DB'(4));
      for (int k = 0; k < 4 && k < glog.size(); k++) chk("urgent_order", DB'(glog[k]), DB'(exp_order[k]));
      drain();

      // write path, then read the word back through another requester
      pat = {64{24'hC8C8C8}};
      t_addr[1] = 30'h2A; t_wdata[1] = pat; t_wen = 3'b010; t_addr[0] = 30'h2A;
      drive(3'b010, 3'b000, 1'b0, 1'b0); step();
      drive(3'b001, 3'b000, 1'b0, 1'b0); step(); step(); step();
      drain();
      chk("sram_written", sram[10'h2A], pat);
      chk("write_readback", bus.rdata, pat);

      // randomized traffic
      do_reset();
      repeat (800) begin
         drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0), 1'b1);
         step();
      end
      drain();

      // WAIT_CYCLES=3 instance: read latency
      @(posedge clk); #1; n_rst3 = 1'b1;
      u_addr0 = 30'd7; u_wen = 3'b000; u_req = 3'b001;
      @(negedge clk); chk("w3_gnt", DB'(bus3.gnt), DB'(3'b001));
      @(posedge clk); #1; u_req = 3'b000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("w3_r_en", DB'(bus3.mem_r_en), DB'(1));
         chk("w3_no_ack", DB'(bus3.ack), DB'(0));
      end
      @(negedge clk);
      chk("w3_ack", DB'(bus3.ack), DB'(3'b001));
      chk("w3_r_en_off", DB'(bus3.mem_r_en), DB'(0));
      chk("w3_rdata", bus3.rdata, {48{32'd7}});

      // WAIT_CYCLES=3 instance: reset in the second cycle of a write
      @(posedge clk); #1;
      u_addr0 = 30'd9; u_wen = 3'b001; u_req = 3'b001;
      @(negedge clk); chk("rst_gnt", DB'(bus3.gnt), DB'(3'b001));
      @(posedge clk); #1; u_req = 3'b000;
      @(negedge clk); chk("rst_w_en_c1", DB'(bus3.mem_w_en), DB'(1));
      @(posedge clk); #2;
      chk("rst_w_en_c2", DB'(bus3.mem_w_en), DB'(1));
      n_rst3 = 1'b0; #1;
      chk("rst_w_en_drop", DB'(bus3.mem_w_en), DB'(0));
      chk("rst_r_en_drop", DB'(bus3.mem_r_en), DB'(0));
      chk("rst_busy_drop", DB'(bus3.busy), DB'(0));
      @(posedge clk); #1; n_rst3 = 1'b1;
      repeat (4) begin @(negedge clk); chk("rst_no_ack", DB'(bus3.ack), DB'(0)); chk("rst_idle", DB'(bus3.busy), DB'(0)); end
      @(posedge clk); #1; u_wen = 3'b000; u_req = 3'b011;
      @(negedge clk); chk("rst_rr_gnt", DB'(bus3.gnt), DB'(3'b001));
      @(posedge clk); #1; u_req = 3'b000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
